// File: rtl/simplebus_leader_queue_pkg.sv
// Shared types and widths for the simplebus leader request queue.
// Imported by the FIFO, the handshake interface and the leader FSM.
package simplebus_pkg;

    localparam int SB_ADDR_W = 24;
    localparam int SB_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        MID,
        LO,
        RDWAIT,
        WR,
        RESP
    } leader_state_t;

    typedef struct packed {
        logic                 read;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] wdata;
    } sb_req_t;

endpackage

// File: rtl/simplebus_leader_queue_if.sv
// Request/response handshakes plus the unidirectional leader bus outputs.
// slave is the leader block's view, master is the processor/bench view.
interface simplebus_leader_queue_if;
    import simplebus_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_read;
    logic [SB_ADDR_W-1:0] req_addr;
    logic [SB_DATA_W-1:0] req_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [SB_DATA_W-1:0] rsp_rdata;
    logic                 rsp_err;

    logic                 bus_start;
    logic                 bus_read;
    logic [SB_DATA_W-1:0] bus_address;

    modport slave (
        input  req_valid, req_read, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_start, bus_read, bus_address
    );

    modport master (
        output req_valid, req_read, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_start, bus_read, bus_address
    );

endinterface

// File: rtl/simplebus_req_fifo.sv
// In-order request FIFO; pointers wrap naturally since DEPTH is a power of 2.
// Push is ignored when full and pop when empty.
module simplebus_req_fifo
    import simplebus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  sb_req_t                din,
    input  logic                   pop,
    output sb_req_t                dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sb_req_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/simplebus_leader_queue.sv
// Simplebus leader front-end: queues requests and serialises each one
// as start + three address bytes, then a read wait or a one-cycle write.
module simplebus_leader_queue
    import simplebus_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    simplebus_leader_queue_if.slave    sb,
    inout  wire  [SB_DATA_W-1:0]       bus_data,
    inout  wire                        bus_dataValid
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_UP     = UP;
    localparam logic [2:0] S_MID    = MID;
    localparam logic [2:0] S_LO     = LO;
    localparam logic [2:0] S_RDWAIT = RDWAIT;
    localparam logic [2:0] S_WR     = WR;
    localparam logic [2:0] S_RESP   = RESP;

    logic [2:0]             state;
    sb_req_t                cur;
    sb_req_t                head;
    sb_req_t                req_in;
    logic [TW-1:0]          tmo;
    logic [SB_DATA_W-1:0]   rdata;
    logic                   err;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   unused_count;
    logic                   push;
    logic                   pop;
    logic                   dv_hi;
    logic                   in_up;
    logic                   in_mid;
    logic                   in_lo;
    logic                   in_wr;

    assign req_in       = {sb.req_read, sb.req_addr, sb.req_wdata};
    assign sb.req_ready = !reset && !fifo_full;
    assign push         = sb.req_valid && sb.req_ready;
    assign pop          = (state == S_IDLE) && !fifo_empty;
    assign unused_count = ^fifo_count;

    simplebus_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (push),
        .din   (req_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Only an unambiguous 1 counts as a follower reply; X/Z reads as idle.
    assign dv_hi  = (bus_dataValid === 1'b1);

    assign in_up  = (state == S_UP);
    assign in_mid = (state == S_MID);
    assign in_lo  = (state == S_LO);
    assign in_wr  = (state == S_WR);

    assign bus_data      = in_wr ? cur.wdata : 'z;
    assign bus_dataValid = in_wr ? 1'b1 : 1'bz;

    assign sb.bus_start = in_up;
    assign sb.bus_read  = in_lo && cur.read;
    assign sb.rsp_valid = (state == S_RESP);
    assign sb.rsp_rdata = rdata;
    assign sb.rsp_err   = err;

    always_comb begin
        sb.bus_address = '0;
        unique case (1'b1)
            in_up:   sb.bus_address = cur.addr[23:16];
            in_mid:  sb.bus_address = cur.addr[15:8];
            in_lo:   sb.bus_address = cur.addr[7:0];
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            cur   <= '0;
            tmo   <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cur   <= head;
                        state <= S_UP;
                    end
                end
                S_UP:  state <= S_MID;
                S_MID: state <= S_LO;
                S_LO: begin
                    tmo   <= '0;
                    state <= cur.read ? S_RDWAIT : S_WR;
                end
                S_RDWAIT: begin
                    tmo <= tmo + TW'(1);
                    if (dv_hi) begin
                        rdata <= bus_data;
                        err   <= 1'b0;
                        state <= S_RESP;
                    end else if (tmo == TMO_LAST) begin
                        rdata <= '0;
                        err   <= 1'b1;
                        state <= S_RESP;
                    end
                end
                S_WR: begin
                    rdata <= '0;
                    err   <= 1'b0;
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (sb.rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simplebus_leader_queue.sv
// Bench for simplebus_leader_queue: table-driven requests, a follower
// model on the bus, and an in-order response scoreboard.
module tb_simplebus_leader_queue;
    import simplebus_pkg::*;

    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 64;
    localparam int RD_DELAY = 3;

    typedef struct {
        logic        read;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [23:0] addr;
        logic        read;
        logic [7:0]  wdata;
        int          dv;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    wire  [7:0] bus_data;
    wire        bus_dataValid;
    logic       f_drv = 1'b0;
    logic [7:0] f_data = 8'h00;

    assign bus_data      = f_drv ? f_data : 8'bz;
    assign bus_dataValid = f_drv ? 1'b1 : 1'bz;

    simplebus_leader_queue_if sif ();

    simplebus_leader_queue #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sb            (sif),
        .bus_data      (bus_data),
        .bus_dataValid (bus_dataValid)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    vec_t sb_q [$];
    obs_t obs_q [$];
    obs_t obs;
    int   fph      = 0;
    int   fwait    = -1;
    int   start_cyc = 0;
    int   lo_cyc    = 0;
    int   rise_cyc  = 0;
    int   hs_cyc    = 0;
    logic prev_rv   = 1'b0;
    logic [7:0] fmem [0:65535];
    vec_t tbl [8];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endfunction

    // Follower 1 memory, bus monitor and response collector share one edge.
    always @(negedge clock) begin
        logic drv_prev;
        logic lo_now;
        vec_t e;
        obs_t o;
        if (reset) begin
            fph     = 0;
            fwait   = -1;
            f_drv   = 1'b0;
            prev_rv = 1'b0;
        end else begin
            drv_prev = f_drv;
            f_drv    = 1'b0;
            lo_now   = (fph == 2);
            if (!drv_prev && bus_dataValid === 1'b1) begin
                obs.dv++;
                obs.wdata = bus_data;
                if (obs.addr[23:16] == 8'h01)
                    fmem[obs.addr[15:0]] = bus_data;
            end
            if (fwait > 0) begin
                fwait--;
                if (fwait == 0) begin
                    f_drv  = 1'b1;
                    f_data = fmem[obs.addr[15:0]];
                    fwait  = -1;
                end
            end
            if (sif.bus_read)
                check("bus_read_only_in_lo", 32'(lo_now), 1);
            if (sif.bus_start) begin
                check("bus_start_one_cycle", 32'(fph == 1), 0);
                obs = '{addr: {sif.bus_address, 16'h0000}, read: 1'b0,
                        wdata: 8'h00, dv: 0};
                fph = 1;
                start_cyc = cyc;
            end else if (fph == 1) begin
                obs.addr[15:8] = sif.bus_address;
                fph = 2;
            end else if (fph == 2) begin
                obs.addr[7:0] = sif.bus_address;
                obs.read = sif.bus_read;
                fph = 0;
                lo_cyc = cyc;
                if (sif.bus_read && obs.addr[23:16] == 8'h01)
                    fwait = RD_DELAY;
            end
            if (sif.rsp_valid && !prev_rv) begin
                rise_cyc = cyc;
                obs_q.push_back(obs);
            end
            prev_rv = sif.rsp_valid;
            if (sif.rsp_valid && sif.rsp_ready) begin
                hs_cyc = cyc;
                if (sb_q.size() == 0 || obs_q.size() == 0) begin
                    check("unexpected_rsp", 32'(sb_q.size()), 1);
                end else begin
                    e = sb_q.pop_front();
                    o = obs_q.pop_front();
                    check("rsp_rdata", 32'(sif.rsp_rdata), 32'(e.rdata));
                    check("rsp_err", 32'(sif.rsp_err), 32'(e.err));
                    check("bus_addr", 32'(o.addr), 32'(e.addr));
                    check("bus_read_lo", 32'(o.read), 32'(e.read));
                    check("wr_dv_cycles", 32'(o.dv), e.read ? 0 : 1);
                    if (!e.read)
                        check("wr_bus_data", 32'(o.wdata), 32'(e.wdata));
                end
            end
        end
    end

    task automatic send(input logic rd, input logic [23:0] a,
                        input logic [7:0] wd, input logic [7:0] er,
                        input logic ee, output int acc);
        int   n = 0;
        vec_t v;
        sif.req_valid = 1'b1;
        sif.req_read  = rd;
        sif.req_addr  = a;
        sif.req_wdata = wd;
        @(negedge clock);
        while (!sif.req_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("req_accept", 32'(sif.req_ready), 1);
        if (sif.req_ready) begin
            v = '{read: rd, addr: a, wdata: wd, rdata: er, err: ee};
            sb_q.push_back(v);
        end
        @(posedge clock);
        #1;
        acc = cyc;
        sif.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || sif.rsp_valid) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("drained", 32'(sb_q.size()), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic check_released(string tag);
        check({tag, "_rsp_valid"}, 32'(sif.rsp_valid), 0);
        check({tag, "_rsp_err"}, 32'(sif.rsp_err), 0);
        check({tag, "_bus_start"}, 32'(sif.bus_start), 0);
        check({tag, "_bus_read"}, 32'(sif.bus_read), 0);
        check({tag, "_bus_address"}, 32'(sif.bus_address), 0);
        check({tag, "_dv_not_high"}, 32'(bus_dataValid === 1'b1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc5;
        int n;
        int seen_rv;
        int seen_st;

        tbl[0] = '{1'b0, 24'h010406, 8'hDC, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 24'h010406, 8'h00, 8'hDC, 1'b0};
        tbl[2] = '{1'b0, 24'h0100AB, 8'h5A, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 24'h0100AB, 8'h00, 8'h5A, 1'b0};
        tbl[4] = '{1'b0, 24'h01FFFF, 8'h3C, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 24'h01FFFF, 8'h00, 8'h3C, 1'b0};
        tbl[6] = '{1'b1, 24'h070000, 8'h00, 8'h00, 1'b1};
        tbl[7] = '{1'b1, 24'h010406, 8'h00, 8'hDC, 1'b0};

        sif.req_valid = 1'b0;
        sif.req_read  = 1'b0;
        sif.req_addr  = '0;
        sif.req_wdata = '0;
        sif.rsp_ready = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("ready_in_reset", 32'(sif.req_ready), 0);
        check_released("reset");
        check("reset_rsp_rdata", 32'(sif.rsp_rdata), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(sif.req_ready), 1);

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].read, tbl[i].addr, tbl[i].wdata,
                 tbl[i].rdata, tbl[i].err, acc);
            drain();
            check("start_latency", 32'(start_cyc - acc), 1);
            if (!tbl[i].read)
                check("wr_rsp_latency", 32'(rise_cyc - acc), 5);
            else if (tbl[i].err)
                check("tmo_rsp_latency", 32'(rise_cyc - lo_cyc), TIMEOUT + 1);
            else
                check("rd_rsp_latency", 32'(rise_cyc - lo_cyc), RD_DELAY + 1);
        end
        check("follower_mem_0406", 32'(fmem[16'h0406]), 32'h00DC);
        check("follower_mem_ffff", 32'(fmem[16'hFFFF]), 32'h003C);

        // Pending response blocks the bus while the FIFO fills.
        sif.rsp_ready = 1'b0;
        send(1'b1, 24'h010406, 8'h00, 8'hDC, 1'b0, acc);
        send(1'b0, 24'h010020, 8'h11, 8'h00, 1'b0, acc);
        send(1'b0, 24'h010021, 8'h22, 8'h00, 1'b0, acc);
        send(1'b1, 24'h010020, 8'h00, 8'h11, 1'b0, acc);
        send(1'b1, 24'h050000, 8'h00, 8'h00, 1'b1, acc);
        @(negedge clock);
        check("ready_when_full", 32'(sif.req_ready), 0);
        n = 0;
        while (!sif.rsp_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("rsp_pending", 32'(sif.rsp_valid), 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("hold_rsp_valid", 32'(sif.rsp_valid), 1);
            check("hold_rsp_rdata", 32'(sif.rsp_rdata), 32'h00DC);
            check("hold_bus_start", 32'(sif.bus_start), 0);
            check("hold_req_ready", 32'(sif.req_ready), 0);
        end
        fork
            send(1'b1, 24'h010021, 8'h00, 8'h22, 1'b0, acc5);
            begin
                @(posedge clock);
                #1 sif.rsp_ready = 1'b1;
            end
        join
        check("refill_after_pop", 32'(acc5 - hs_cyc), 3);
        drain();
        check("follower_mem_0020", 32'(fmem[16'h0020]), 32'h0011);

        // Reset while a read waits on an absent follower, two more queued.
        send(1'b1, 24'h060000, 8'h00, 8'h00, 1'b1, acc);
        send(1'b1, 24'h010406, 8'h00, 8'hDC, 1'b0, acc);
        send(1'b0, 24'h010040, 8'h99, 8'h00, 1'b0, acc);
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("ready_in_mid_reset", 32'(sif.req_ready), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb_q.delete();
        obs_q.delete();
        #1;
        check_released("mid_reset");
        check("ready_after_mid_reset", 32'(sif.req_ready), 1);
        seen_rv = 0;
        seen_st = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            if (sif.rsp_valid) seen_rv++;
            if (sif.bus_start) seen_st++;
        end
        check("no_stale_rsp", 32'(seen_rv), 0);
        check("no_stale_start", 32'(seen_st), 0);

        @(posedge clock);
        #1;
        send(1'b0, 24'h010040, 8'h77, 8'h00, 1'b0, acc);
        send(1'b1, 24'h010040, 8'h00, 8'h77, 1'b0, acc);
        drain();
        check("follower_mem_0040", 32'(fmem[16'h0040]), 32'h0077);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/simplebus_leader_queue.md
Name: simplebus_leader_queue

Overview:
- Front-end for the processor side of the simplebus.
- Accepts byte read/write requests on a valid/ready request port and buffers them in an in-order FIFO.
- Serialises each request onto the bus using the leader protocol: start, three address bytes, then a read wait or a one-cycle write.
- Returns exactly one response per request, in order. A read timeout bounds any transaction aimed at an unmapped follower.

Parameters:
- DEPTH, 4: request FIFO entries (power of 2, at least 2).
- TIMEOUT, 64: clock cycles waited in RDWAIT for dataValid before an error response (at least 2).

Ports:
- clock  in  1  single clock, shared with every bus follower.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid and req_ready are both high at a clock edge.
- req_read  in  1  1 = read, 0 = write.
- req_addr  in  24  byte address; [23:16] selects the follower.
- req_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  response available; held until accepted.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  8  read data; 8'h00 for writes and for errors.
- rsp_err  out  1  1 = read timed out.
- bus_start  out  1  transaction start.
- bus_read  out  1  read qualifier, valid in the LO cycle only.
- bus_address  out  8  address byte.
- bus_data  inout  8  driven only in WR, 'z otherwise.
- bus_dataValid  inout  1  driven only in WR, 'z otherwise; in RDWAIT it is an input from the follower.

Behaviour:
- Reset values: req_ready=0 during reset and 1 after; rsp_valid=0; rsp_rdata=0; rsp_err=0; bus_start=0; bus_read=0; bus_address=0; bus_data and bus_dataValid='z; FIFO empty; state IDLE.
- FIFO:
  - req_ready = (count != DEPTH), taken from registered count with no same-cycle bypass. A full FIFO stays not-ready even in a cycle where it pops.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- States: IDLE, UP, MID, LO, RDWAIT, WR, RESP.
- IDLE: if FIFO non-empty, pop the head into the current-transaction registers and go to UP. Otherwise stay in IDLE.
- UP: bus_start=1, bus_address=addr[23:16]; go to MID.
- MID: bus_address=addr[15:8]; go to LO.
- LO: bus_address=addr[7:0], bus_read=read. Go to RDWAIT if read, else WR.
- RDWAIT:
  - The timeout counter clears on entry and increments each cycle.
  - If bus_dataValid==1: register bus_data into rsp_rdata, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: rsp_rdata=8'h00, rsp_err=1, go to RESP.
  - dataValid takes priority if both conditions occur in the same cycle.
  - An X/Z value on bus_dataValid is treated as 0.
- WR: drive bus_data=wdata and bus_dataValid=1 for exactly one cycle; rsp_rdata=0, rsp_err=0; go to RESP.
- RESP: rsp_valid=1 and the rsp fields stay stable. On rsp_ready go to IDLE. No new bus transaction starts while a response is pending.
- bus_address=8'h00 in every state other than UP, MID and LO.
- Latency, measured from the request-accept edge E0 into an empty, idle block:
  - bus_start is high in the cycle after E1.
  - Write: rsp_valid rises after E5.
  - Read: rsp_valid rises on the edge after the cycle in which dataValid is sampled high.
- Back-to-back: the minimum gap is one IDLE cycle between RESP acceptance and the next UP.
- Reset mid-operation: on the next edge the FIFO is flushed, the state returns to IDLE, rsp_valid=0 and the bus is released. Any in-flight request is lost with no response.

Decomposition:
- Package simplebus_pkg holds:
  - typedef enum leader_state_t {IDLE, UP, MID, LO, RDWAIT, WR, RESP};
  - typedef struct packed sb_req_t {logic read; logic [23:0] addr; logic [7:0] wdata;};
  - localparam SB_ADDR_W=24 and SB_DATA_W=8.
- Sub-module simplebus_req_fifo: synchronous FIFO of sb_req_t with parameter DEPTH and push/pop/full/empty/count.

Test Plan:
- Write 24'h010406 <- 8'hDC with follower 1 present: bus_start for 1 cycle; address bytes 01, 04, 06; bus_read=0; bus_data=DC with dataValid=1 for 1 cycle; rsp_valid after E5 with rsp_err=0, rsp_rdata=00; follower memory[0x0406]=DC.
- Read 24'h010406 after that write, follower asserting dataValid 3 cycles after LO: bus_read=1 only in LO; rsp_rdata=DC, rsp_err=0.
- Push 5 requests back-to-back with DEPTH=4 and the bus busy: req_ready drops after the 4th accept and recovers once the first entry pops; all 5 responses return in push order.
- Read 24'h070000 with no follower 7: rsp_err=1 and rsp_rdata=00 exactly TIMEOUT cycles after entering RDWAIT; the next queued request then proceeds normally.
- Hold rsp_ready=0 for 10 cycles on a completed read: rsp_valid and rsp_rdata stay stable; bus_start stays 0 despite a non-empty FIFO.
- Assert reset for 1 cycle during RDWAIT with 2 entries queued: the next cycle shows IDLE, empty FIFO, rsp_valid=0 and bus_dataValid/bus_data='z; no stale response after reset.
